melody_sequencer: RTL

Sequences a melody stored in a combinational melody ROM and drives the note/octave inputs of the pitch generator, one entry at a time, for a programmed duration. Sits between the top-level control (buttons/keyboard mode select) and pitch_generator. Provides start/stop/pause, optional looping, a rest code, and a short muted gap between consecutive notes for articulation.

---
 rtl/melody_pkg.sv | 22 ++
 rtl/melody_sequencer_tick_prescaler.sv | 27 ++
 rtl/melody_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - shared constants, ROM field layout and FSM states for melody_sequencer
package melody_pkg;

    localparam logic [3:0] REST_NOTE    = 4'hF;
    localparam logic [7:0] END_DURATION = 8'd0;

    localparam int NOTE_HI = 15;
    localparam int NOTE_LO = 12;
    localparam int OCT_HI  = 11;
    localparam int OCT_LO  = 8;
    localparam int DUR_HI  = 7;
    localparam int DUR_LO  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PLAY,
        ST_GAP,
        ST_PAUSED
    } state_t;

endpackage

// File: rtl/melody_sequencer_tick_prescaler.sv
// rtl/melody_sequencer_tick_prescaler.sv - divides clk into one-cycle duration ticks
module tick_prescaler #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - steps through the melody ROM and drives note/octave/mute to the pitch generator
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int TICK_DIV  = 12_500_000,
    parameter int ADDR_W    = 8,
    parameter int GAP_TICKS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [3:0]        note,
    output logic [3:0]        octave,
    output logic              mute,
    output logic              playing,
    output logic              done
);

    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

    state_t           state;
    state_t           saved_state;
    logic [7:0]       dur_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             is_rest;
    logic             tick;
    logic             presc_clear;
    logic             presc_enable;

    logic [3:0] rom_note;
    logic [3:0] rom_oct;
    logic [7:0] rom_dur;
    logic       play_done;
    logic       gap_done;
    logic       advance;
    logic       wrap_end;

    assign rom_note = rom_data[NOTE_HI:NOTE_LO];
    assign rom_oct  = rom_data[OCT_HI:OCT_LO];
    assign rom_dur  = rom_data[DUR_HI:DUR_LO];

    assign play_done = (state == ST_PLAY) && tick && (dur_cnt == 8'd1);
    assign gap_done  = (state == ST_GAP) && tick && (gap_cnt == GAP_W'(1));
    assign advance   = (play_done && (GAP_TICKS == 0)) || gap_done;
    assign wrap_end  = (rom_addr == '1) && !loop;

    assign presc_clear  = (state == ST_FETCH) || start || stop;
    assign presc_enable = (state == ST_PLAY) || (state == ST_GAP);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (presc_clear),
        .enable(presc_enable),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            saved_state <= ST_IDLE;
            rom_addr    <= '0;
            note        <= 4'd0;
            octave      <= 4'd0;
            mute        <= 1'b1;
            playing     <= 1'b0;
            done        <= 1'b0;
            dur_cnt     <= 8'd0;
            gap_cnt     <= '0;
            is_rest     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= ST_IDLE;
                rom_addr <= '0;
                mute     <= 1'b1;
                playing  <= 1'b0;
            end else if (start) begin
                state    <= ST_FETCH;
                rom_addr <= '0;
                mute     <= 1'b1;
                playing  <= 1'b1;
                dur_cnt  <= 8'd0;
                gap_cnt  <= '0;
            end else if (advance) begin
                // Entry finished; a pause arriving now lands on the next PLAY cycle.
                dur_cnt <= 8'd0;
                gap_cnt <= '0;
                if (wrap_end) begin
                    state    <= ST_IDLE;
                    rom_addr <= '0;
                    mute     <= 1'b1;
                    playing  <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    state    <= ST_FETCH;
                    rom_addr <= rom_addr + ADDR_W'(1);
                end
            end else begin
                case (state)
                    ST_FETCH: begin
                        if (rom_dur == END_DURATION) begin
                            if (loop) begin
                                rom_addr <= '0;
                            end else begin
                                state    <= ST_IDLE;
                                rom_addr <= '0;
                                mute     <= 1'b1;
                                playing  <= 1'b0;
                                done     <= 1'b1;
                            end
                        end else begin
                            if (rom_note != REST_NOTE) begin
                                note   <= rom_note;
                                octave <= rom_oct;
                            end
                            is_rest <= (rom_note == REST_NOTE);
                            mute    <= (rom_note == REST_NOTE);
                            dur_cnt <= rom_dur;
                            state   <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (tick) begin
                            dur_cnt <= dur_cnt - 8'd1;
                        end
                        if (play_done) begin
                            gap_cnt <= GAP_W'(GAP_TICKS);
                        end
                        // The pause cycle still counts, so the state to resume is the one this tick leads to.
                        if (pause) begin
                            state       <= ST_PAUSED;
                            saved_state <= play_done ? ST_GAP : ST_PLAY;
                            mute        <= 1'b1;
                        end else if (play_done) begin
                            state <= ST_GAP;
                            mute  <= 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (tick) begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end
                        if (pause) begin
                            state       <= ST_PAUSED;
                            saved_state <= ST_GAP;
                            mute        <= 1'b1;
                        end
                    end
                    ST_PAUSED: begin
                        if (!pause) begin
                            state <= saved_state;
                            mute  <= (saved_state == ST_GAP) || is_rest;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
